// File: rtl/hamming_decode_sequencer_pkg.sv
// hamming_decode_sequencer_pkg: (15,11) Hamming constants, sequencer state encoding and syndrome helper
package hamming_decode_sequencer_pkg;
  localparam int CW_LEN = 15;
  localparam int DATA_LEN = 11;
  localparam logic [3:0] LAST_COUNT = 4'd14;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    HOLD  = 2'd3
  } state_t;
  // cw[i] carries codeword position i+1
  function automatic logic [3:0] syndrome_of(input logic [CW_LEN-1:0] cw);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < CW_LEN; i++) s = cw[i] ? s ^ 4'(i + 1) : s;
    return s;
  endfunction
endpackage

// File: rtl/hamming_decode_sequencer_syndrome.sv
// hamming_15_11_syndrome: combinational codeword -> syndrome and (optionally corrected) 11-bit data
module hamming_15_11_syndrome
  import hamming_decode_sequencer_pkg::*;
#(
  parameter bit CORRECT_EN = 1'b1
) (
  input  logic [CW_LEN-1:0]   cw,
  output logic [3:0]          syn,
  output logic [DATA_LEN-1:0] data
);
  localparam logic [3:0] DPOS [DATA_LEN] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
  always_comb begin
    syn = syndrome_of(cw);
    for (int j = 0; j < DATA_LEN; j++) data[j] = cw[DPOS[j] - 4'd1] ^ (CORRECT_EN && syn == DPOS[j]);
  end
endmodule

// File: rtl/hamming_decode_sequencer.sv
// hamming_decode_sequencer: serial (15,11) Hamming receiver; shifts a codeword in, corrects
// a single-bit error and presents the data word on a valid/ready handshake.
module hamming_decode_sequencer
  import hamming_decode_sequencer_pkg::*;
#(
  parameter int ERR_CNT_W = 8,
  parameter bit CORRECT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rest_n,
  input  logic                 device_en,
  input  logic                 frame_abort,
  input  logic                 ser_in,
  input  logic                 ser_valid,
  output logic                 ser_ready,
  output logic [DATA_LEN-1:0]  data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic [3:0]           syndrome,
  output logic                 err_det,
  output logic [ERR_CNT_W-1:0] err_count
);
  state_t state_q, state_d;
  logic live_q;
  logic [3:0] cnt_q, cnt_d;
  logic [CW_LEN-1:0] sr_q, sr_d;
  logic [DATA_LEN-1:0] data_q, data_d, fix_data;
  logic [3:0] syn_q, syn_d, syn_now;
  logic err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic accept, load;

  hamming_15_11_syndrome #(.CORRECT_EN(CORRECT_EN)) u_syn (
    .cw   (sr_q),
    .syn  (syn_now),
    .data (fix_data)
  );

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? SHIFT : IDLE;
      SHIFT:   state_d = (accept && cnt_q == LAST_COUNT) ? CHECK : SHIFT;
      CHECK:   state_d = HOLD;
      HOLD:    state_d = data_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
    if (frame_abort) state_d = IDLE;
  end

  // live_q keeps ser_ready low until the first clock after reset release
  always_comb begin
    ser_ready = live_q && device_en && (state_q == IDLE || state_q == SHIFT);
    data_valid = state_q == HOLD;
    data_out = data_q;
    syndrome = syn_q;
    err_det = err_q;
    err_count = err_cnt_q;
  end

  always_comb begin
    accept = ser_valid && ser_ready;
    load = state_q == CHECK && !frame_abort;
    cnt_d = frame_abort ? 4'd0 : accept ? (cnt_q == LAST_COUNT ? 4'd0 : cnt_q + 4'd1) : cnt_q;
    sr_d = frame_abort ? '0 : accept ? {sr_q[CW_LEN-2:0], ser_in} : sr_q;
    data_d = load ? fix_data : data_q;
    syn_d = load ? syn_now : syn_q;
    err_d = load ? syn_now != 4'd0 : err_q;
    err_cnt_d = (load && syn_now != 4'd0 && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      live_q <= 1'b0;
      cnt_q <= 4'd0;
      sr_q <= '0;
      data_q <= '0;
      syn_q <= 4'd0;
      err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      live_q <= 1'b1;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      data_q <= data_d;
      syn_q <= syn_d;
      err_q <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule
